// File: rtl/rapid_pkg.sv
// Shared types for the RAPID pipeline: control bundles, memory width codes
// and memory-access-unit FSM states.
package rapid_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned RD_W = 5;

    // Control bundle from execute toward the memory stage.
    typedef struct packed {
        logic            mem;               // 1 = load/store
        logic            iop;               // 1 = store
        logic [2:0]      fcs_opcode;        // width code
        logic [RD_W-1:0] rd;
        logic [XLEN-1:0] debug_instruction;
    } control_mem_s;

    // Control bundle from the memory stage toward writeback.
    typedef struct packed {
        logic [RD_W-1:0] rd;
        logic            rd_we;
        logic [XLEN-1:0] debug_instruction;
    } control_wb_s;

    // Access width encodings carried in fcs_opcode.
    localparam logic [2:0] MEM_B  = 3'b000;
    localparam logic [2:0] MEM_H  = 3'b001;
    localparam logic [2:0] MEM_W  = 3'b010;
    localparam logic [2:0] MEM_BU = 3'b100;
    localparam logic [2:0] MEM_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } mau_state_e;

endpackage

// File: rtl/load_store_align.sv
// Combinational byte-lane steering for the data-memory bus.
// Ports:
//   addr_lo_i      - effective address bits [1:0]
//   width_i        - width code (MEM_*)
//   is_store_i     - 1 = store
//   store_data_i   - raw store data (rs2)
//   rdata_i        - raw load word from the bus
//   be_c_o         - byte enables for the access
//   wdata_c_o      - lane-replicated store data
//   misaligned_c_o - address not aligned to the access width
//   illegal_c_o    - width code not legal for this access kind
//   load_data_c_o  - extracted and extended load value
module load_store_align
    import rapid_pkg::*;
(
    input  logic [1:0]      addr_lo_i,
    input  logic [2:0]      width_i,
    input  logic            is_store_i,
    input  logic [XLEN-1:0] store_data_i,
    input  logic [XLEN-1:0] rdata_i,
    output logic [3:0]      be_c_o,
    output logic [XLEN-1:0] wdata_c_o,
    output logic            misaligned_c_o,
    output logic            illegal_c_o,
    output logic [XLEN-1:0] load_data_c_o
);

    // Addressed lane of the load word, shifted down to bit 0.
    logic [15:0] lane;

    always_comb begin
        lane           = 16'(rdata_i >> {addr_lo_i, 3'b000});
        be_c_o         = 4'b0000;
        wdata_c_o      = store_data_i;
        misaligned_c_o = 1'b0;
        illegal_c_o    = 1'b0;
        load_data_c_o  = '0;
        case (width_i)
            MEM_B: begin
                be_c_o        = 4'b0001 << addr_lo_i;
                wdata_c_o     = {4{store_data_i[7:0]}};
                load_data_c_o = {{(XLEN-8){lane[7]}}, lane[7:0]};
            end
            MEM_BU: begin
                be_c_o        = 4'b0001 << addr_lo_i;
                illegal_c_o   = is_store_i;
                load_data_c_o = {{(XLEN-8){1'b0}}, lane[7:0]};
            end
            MEM_H: begin
                be_c_o         = 4'b0011 << {addr_lo_i[1], 1'b0};
                wdata_c_o      = {2{store_data_i[15:0]}};
                misaligned_c_o = addr_lo_i[0];
                load_data_c_o  = {{(XLEN-16){lane[15]}}, lane[15:0]};
            end
            MEM_HU: begin
                be_c_o         = 4'b0011 << {addr_lo_i[1], 1'b0};
                illegal_c_o    = is_store_i;
                // Illegal takes precedence so the flags stay exclusive.
                misaligned_c_o = addr_lo_i[0] & ~is_store_i;
                load_data_c_o  = {{(XLEN-16){1'b0}}, lane[15:0]};
            end
            MEM_W: begin
                be_c_o         = 4'b1111;
                misaligned_c_o = (addr_lo_i != 2'b00);
                load_data_c_o  = rdata_i;
            end
            default: begin
                illegal_c_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/memory_access_unit.sv
// Memory stage: passes ALU results through and runs single-outstanding
// req/gnt/rvalid transactions for loads and stores, with registered
// results, alignment and bus-timeout exceptions toward writeback.
// Ports:
//   i_clk, i_rst_n        - clock, async active-low reset
//   i_valid / o_ready     - execute handshake (o_ready = state is IDLE)
//   i_control_signal      - control bundle from execute
//   i_alu_result          - rd value, or effective address for mem ops
//   i_memory_data         - store data
//   o_dmem_*              - data-memory request channel
//   i_dmem_gnt            - request accepted
//   i_dmem_rvalid/rdata   - load response
//   o_valid               - one-cycle writeback result pulse
//   o_control_signal      - writeback control bundle
//   o_rd_output           - writeback value
//   o_misaligned          - alignment exception (qualified by o_valid)
//   o_bus_error           - timeout / illegal width (qualified by o_valid)
module memory_access_unit
    import rapid_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_valid,
    output logic            o_ready,
    input  control_mem_s    i_control_signal,
    input  logic [XLEN-1:0] i_alu_result,
    input  logic [XLEN-1:0] i_memory_data,
    output logic            o_dmem_req,
    output logic            o_dmem_we,
    output logic [XLEN-1:0] o_dmem_addr,
    output logic [XLEN-1:0] o_dmem_wdata,
    output logic [3:0]      o_dmem_be,
    input  logic            i_dmem_gnt,
    input  logic            i_dmem_rvalid,
    input  logic [XLEN-1:0] i_dmem_rdata,
    output logic            o_valid,
    output control_wb_s     o_control_signal,
    output logic [XLEN-1:0] o_rd_output,
    output logic            o_misaligned,
    output logic            o_bus_error
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    mau_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Captured at acceptance, used while the transaction is in flight.
    logic [1:0]      addr_lo_q, addr_lo_d;
    logic [2:0]      width_q, width_d;
    logic [RD_W-1:0] rd_q, rd_d;
    logic [XLEN-1:0] dbg_q, dbg_d;

    logic            req_q, req_d;
    logic            we_q, we_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [3:0]      be_q, be_d;
    logic            valid_q, valid_d;
    control_wb_s     wb_q, wb_d;
    logic [XLEN-1:0] rd_out_q, rd_out_d;
    logic            mis_q, mis_d;
    logic            berr_q, berr_d;

    logic [1:0]      lsa_addr_lo;
    logic [2:0]      lsa_width;
    logic [3:0]      lsa_be;
    logic [XLEN-1:0] lsa_wdata;
    logic            lsa_mis;
    logic            lsa_ill;
    logic [XLEN-1:0] lsa_load;

    // In IDLE the aligner sees the incoming request; otherwise the captured one.
    assign lsa_addr_lo = (state_q == IDLE) ? i_alu_result[1:0] : addr_lo_q;
    assign lsa_width   = (state_q == IDLE) ? i_control_signal.fcs_opcode : width_q;

    load_store_align u_align (
        .addr_lo_i      (lsa_addr_lo),
        .width_i        (lsa_width),
        .is_store_i     (i_control_signal.iop),
        .store_data_i   (i_memory_data),
        .rdata_i        (i_dmem_rdata),
        .be_c_o         (lsa_be),
        .wdata_c_o      (lsa_wdata),
        .misaligned_c_o (lsa_mis),
        .illegal_c_o    (lsa_ill),
        .load_data_c_o  (lsa_load)
    );

    // Next-state and output logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_lo_d = addr_lo_q;
        width_d   = width_q;
        rd_d      = rd_q;
        dbg_d     = dbg_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        valid_d   = 1'b0;
        wb_d      = wb_q;
        rd_out_d  = rd_out_q;
        mis_d     = mis_q;
        berr_d    = berr_q;

        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    addr_lo_d = i_alu_result[1:0];
                    width_d   = i_control_signal.fcs_opcode;
                    rd_d      = i_control_signal.rd;
                    dbg_d     = i_control_signal.debug_instruction;
                    wb_d.rd                = i_control_signal.rd;
                    wb_d.debug_instruction = i_control_signal.debug_instruction;
                    wb_d.rd_we             = 1'b0;
                    mis_d     = 1'b0;
                    berr_d    = 1'b0;
                    if (!i_control_signal.mem) begin
                        valid_d    = 1'b1;
                        rd_out_d   = i_alu_result;
                        wb_d.rd_we = (i_control_signal.rd != '0);
                    end else if (lsa_ill) begin
                        valid_d = 1'b1;
                        berr_d  = 1'b1;
                    end else if (lsa_mis) begin
                        valid_d  = 1'b1;
                        mis_d    = 1'b1;
                        rd_out_d = i_alu_result;
                    end else begin
                        state_d = REQ;
                        cnt_d   = '0;
                        req_d   = 1'b1;
                        we_d    = i_control_signal.iop;
                        addr_d  = {i_alu_result[XLEN-1:2], 2'b00};
                        be_d    = lsa_be;
                        wdata_d = lsa_wdata;
                    end
                end
            end
            REQ: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (i_dmem_gnt) begin
                    req_d = 1'b0;
                    if (we_q) begin
                        state_d    = IDLE;
                        valid_d    = 1'b1;
                        wb_d.rd_we = 1'b0;
                    end else begin
                        state_d = WAIT;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    req_d      = 1'b0;
                    state_d    = IDLE;
                    valid_d    = 1'b1;
                    berr_d     = 1'b1;
                    wb_d.rd_we = 1'b0;
                end
            end
            WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (i_dmem_rvalid) begin
                    state_d    = IDLE;
                    valid_d    = 1'b1;
                    rd_out_d   = lsa_load;
                    wb_d.rd_we = (rd_q != '0);
                end else if (cnt_q == CNT_LAST) begin
                    state_d    = IDLE;
                    valid_d    = 1'b1;
                    berr_d     = 1'b1;
                    wb_d.rd_we = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_lo_q <= '0;
            width_q   <= '0;
            rd_q      <= '0;
            dbg_q     <= '0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            valid_q   <= 1'b0;
            wb_q      <= '0;
            rd_out_q  <= '0;
            mis_q     <= 1'b0;
            berr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_lo_q <= addr_lo_d;
            width_q   <= width_d;
            rd_q      <= rd_d;
            dbg_q     <= dbg_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            valid_q   <= valid_d;
            wb_q      <= wb_d;
            rd_out_q  <= rd_out_d;
            mis_q     <= mis_d;
            berr_q    <= berr_d;
        end
    end

    assign o_ready          = (state_q == IDLE);
    assign o_dmem_req       = req_q;
    assign o_dmem_we        = we_q;
    assign o_dmem_addr      = addr_q;
    assign o_dmem_wdata     = wdata_q;
    assign o_dmem_be        = be_q;
    assign o_valid          = valid_q;
    assign o_control_signal = wb_q;
    assign o_rd_output      = rd_out_q;
    assign o_misaligned     = mis_q;
    assign o_bus_error      = berr_q;

endmodule

// File: tb/tb_memory_access_unit.sv
// Directed bench for memory_access_unit: table of single transactions plus
// hand sequences for back-to-back, stalled grant, timeout and reset.
module tb_memory_access_unit;
    import rapid_pkg::*;

    logic            i_clk;
    logic            i_rst_n;
    logic            i_valid;
    logic            o_ready;
    control_mem_s    i_control_signal;
    logic [XLEN-1:0] i_alu_result;
    logic [XLEN-1:0] i_memory_data;
    logic            o_dmem_req;
    logic            o_dmem_we;
    logic [XLEN-1:0] o_dmem_addr;
    logic [XLEN-1:0] o_dmem_wdata;
    logic [3:0]      o_dmem_be;
    logic            i_dmem_gnt;
    logic            i_dmem_rvalid;
    logic [XLEN-1:0] i_dmem_rdata;
    logic            o_valid;
    control_wb_s     o_control_signal;
    logic [XLEN-1:0] o_rd_output;
    logic            o_misaligned;
    logic            o_bus_error;

    int n_checks;
    int n_errors;

    memory_access_unit #(.TIMEOUT_CYCLES(4)) dut (
        .i_clk            (i_clk),
        .i_rst_n          (i_rst_n),
        .i_valid          (i_valid),
        .o_ready          (o_ready),
        .i_control_signal (i_control_signal),
        .i_alu_result     (i_alu_result),
        .i_memory_data    (i_memory_data),
        .o_dmem_req       (o_dmem_req),
        .o_dmem_we        (o_dmem_we),
        .o_dmem_addr      (o_dmem_addr),
        .o_dmem_wdata     (o_dmem_wdata),
        .o_dmem_be        (o_dmem_be),
        .i_dmem_gnt       (i_dmem_gnt),
        .i_dmem_rvalid    (i_dmem_rvalid),
        .i_dmem_rdata     (i_dmem_rdata),
        .o_valid          (o_valid),
        .o_control_signal (o_control_signal),
        .o_rd_output      (o_rd_output),
        .o_misaligned     (o_misaligned),
        .o_bus_error      (o_bus_error)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    typedef struct {
        logic        mem;
        logic        iop;
        logic [2:0]  op;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] data;
        logic [31:0] rdata;
        logic        exp_req;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic        chk_rd;
        logic [31:0] exp_rd;
        logic        exp_we;
        logic        exp_mis;
        logic        exp_berr;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive(input logic mem, input logic iop, input logic [2:0] op,
                         input logic [4:0] rd, input logic [31:0] alu,
                         input logic [31:0] data, input logic [31:0] dbg);
        i_valid = 1'b1;
        i_control_signal.mem = mem;
        i_control_signal.iop = iop;
        i_control_signal.fcs_opcode = op;
        i_control_signal.rd = rd;
        i_control_signal.debug_instruction = dbg;
        i_alu_result = alu;
        i_memory_data = data;
    endtask

    // One transaction: gnt in the first REQ cycle, rvalid in the next.
    task automatic run_vec(input vec_t v, input logic [31:0] dbg);
        drive(v.mem, v.iop, v.op, v.rd, v.alu, v.data, dbg);
        step();
        i_valid = 1'b0;
        if (v.exp_req) begin
            chk("req_hi", 64'(o_dmem_req), 64'(1'b1));
            chk("ready_lo", 64'(o_ready), 64'(1'b0));
            chk("addr", 64'(o_dmem_addr), 64'({v.alu[31:2], 2'b00}));
            chk("be", 64'(o_dmem_be), 64'(v.exp_be));
            chk("we", 64'(o_dmem_we), 64'(v.iop));
            if (v.iop) chk("wdata", 64'(o_dmem_wdata), 64'(v.exp_wdata));
            i_dmem_gnt = 1'b1;
            step();
            i_dmem_gnt = 1'b0;
            if (!v.iop) begin
                chk("req_dropped", 64'(o_dmem_req), 64'(1'b0));
                chk("wait_novalid", 64'(o_valid), 64'(1'b0));
                i_dmem_rvalid = 1'b1;
                i_dmem_rdata = v.rdata;
                step();
                i_dmem_rvalid = 1'b0;
            end
        end else begin
            chk("no_req", 64'(o_dmem_req), 64'(1'b0));
        end
        chk("valid", 64'(o_valid), 64'(1'b1));
        chk("ready_res", 64'(o_ready), 64'(1'b1));
        chk("rd_we", 64'(o_control_signal.rd_we), 64'(v.exp_we));
        chk("misaligned", 64'(o_misaligned), 64'(v.exp_mis));
        chk("bus_error", 64'(o_bus_error), 64'(v.exp_berr));
        chk("dbg", 64'(o_control_signal.debug_instruction), 64'(dbg));
        if (v.chk_rd) begin
            chk("rd_output", 64'(o_rd_output), 64'(v.exp_rd));
            chk("rd", 64'(o_control_signal.rd), 64'(v.rd));
        end
        step();
        chk("valid_pulse", 64'(o_valid), 64'(1'b0));
    endtask

    initial begin
        bit got;
        int n_req;
        n_checks = 0;
        n_errors = 0;
        i_rst_n = 1'b0;
        i_valid = 1'b0;
        i_control_signal = '0;
        i_alu_result = '0;
        i_memory_data = '0;
        i_dmem_gnt = 1'b0;
        i_dmem_rvalid = 1'b0;
        i_dmem_rdata = '0;

        //          mem iop op      rd  alu           data          rdata         req be       wdata        chk exp_rd        we mis berr
        vecs[0]  = '{1'b0,1'b0,3'b000,5'd5,32'h0000_1234,32'h0,       32'h0,       1'b0,4'b0000,32'h0,       1'b1,32'h0000_1234,1'b1,1'b0,1'b0};
        vecs[1]  = '{1'b0,1'b0,3'b000,5'd0,32'h0000_0055,32'h0,       32'h0,       1'b0,4'b0000,32'h0,       1'b1,32'h0000_0055,1'b0,1'b0,1'b0};
        vecs[2]  = '{1'b1,1'b1,MEM_B, 5'd3,32'h0000_1003,32'hAABBCCDD,32'h0,       1'b1,4'b1000,32'hDDDDDDDD,1'b0,32'h0,       1'b0,1'b0,1'b0};
        vecs[3]  = '{1'b1,1'b1,MEM_H, 5'd3,32'h0000_1002,32'h11223344,32'h0,       1'b1,4'b1100,32'h33443344,1'b0,32'h0,       1'b0,1'b0,1'b0};
        vecs[4]  = '{1'b1,1'b1,MEM_W, 5'd3,32'h0000_1004,32'hCAFEF00D,32'h0,       1'b1,4'b1111,32'hCAFEF00D,1'b0,32'h0,       1'b0,1'b0,1'b0};
        vecs[5]  = '{1'b1,1'b0,MEM_B, 5'd6,32'h0000_2001,32'h0,       32'h80FF7F01,1'b1,4'b0010,32'h0,       1'b1,32'h0000_007F,1'b1,1'b0,1'b0};
        vecs[6]  = '{1'b1,1'b0,MEM_B, 5'd6,32'h0000_2003,32'h0,       32'h80FF7F01,1'b1,4'b1000,32'h0,       1'b1,32'hFFFF_FF80,1'b1,1'b0,1'b0};
        vecs[7]  = '{1'b1,1'b0,MEM_HU,5'd7,32'h0000_2002,32'h0,       32'h80FF7F01,1'b1,4'b1100,32'h0,       1'b1,32'h0000_80FF,1'b1,1'b0,1'b0};
        vecs[8]  = '{1'b1,1'b0,MEM_H, 5'd7,32'h0000_2002,32'h0,       32'h80FF7F01,1'b1,4'b1100,32'h0,       1'b1,32'hFFFF_80FF,1'b1,1'b0,1'b0};
        vecs[9]  = '{1'b1,1'b0,MEM_BU,5'd8,32'h0000_2003,32'h0,       32'h80FF7F01,1'b1,4'b1000,32'h0,       1'b1,32'h0000_0080,1'b1,1'b0,1'b0};
        vecs[10] = '{1'b1,1'b0,MEM_W, 5'd8,32'h0000_2000,32'h0,       32'h80FF7F01,1'b1,4'b1111,32'h0,       1'b1,32'h80FF_7F01,1'b1,1'b0,1'b0};
        vecs[11] = '{1'b1,1'b0,MEM_W, 5'd4,32'h0000_3002,32'h0,       32'h0,       1'b0,4'b0000,32'h0,       1'b1,32'h0000_3002,1'b0,1'b1,1'b0};
        vecs[12] = '{1'b1,1'b1,MEM_H, 5'd4,32'h0000_3001,32'h1,       32'h0,       1'b0,4'b0000,32'h0,       1'b1,32'h0000_3001,1'b0,1'b1,1'b0};
        vecs[13] = '{1'b1,1'b0,3'b011,5'd4,32'h0000_3000,32'h0,       32'h0,       1'b0,4'b0000,32'h0,       1'b0,32'h0,       1'b0,1'b0,1'b1};
        vecs[14] = '{1'b1,1'b1,MEM_BU,5'd4,32'h0000_3000,32'h0,       32'h0,       1'b0,4'b0000,32'h0,       1'b0,32'h0,       1'b0,1'b0,1'b1};

        // Reset state.
        #12;
        chk("rst_ready", 64'(o_ready), 64'(1'b1));
        chk("rst_valid", 64'(o_valid), 64'(1'b0));
        chk("rst_req", 64'(o_dmem_req), 64'(1'b0));
        chk("rst_addr", 64'(o_dmem_addr), 64'(0));
        chk("rst_ctrl", 64'(o_control_signal), 64'(0));
        chk("rst_rdout", 64'(o_rd_output), 64'(0));
        step();
        i_rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            run_vec(vecs[i], {16'hD000, 16'(i)});
        end

        // Back-to-back non-mem accepts.
        drive(1'b0, 1'b0, 3'b000, 5'd5, 32'h0000_1234, 32'h0, 32'h13);
        step();
        chk("b2b_valid0", 64'(o_valid), 64'(1'b1));
        chk("b2b_rd0", 64'(o_rd_output), 64'(32'h1234));
        drive(1'b0, 1'b0, 3'b000, 5'd7, 32'h0000_ABCD, 32'h0, 32'h14);
        step();
        i_valid = 1'b0;
        chk("b2b_valid1", 64'(o_valid), 64'(1'b1));
        chk("b2b_rd1", 64'(o_rd_output), 64'(32'hABCD));
        chk("b2b_rdidx1", 64'(o_control_signal.rd), 64'(5'd7));
        step();

        // Store with grant held off for two cycles: request must stay stable.
        drive(1'b1, 1'b1, MEM_W, 5'd2, 32'h0000_5008, 32'h1234_5678, 32'h15);
        step();
        i_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk("stall_req", 64'(o_dmem_req), 64'(1'b1));
            chk("stall_addr", 64'(o_dmem_addr), 64'(32'h5008));
            chk("stall_wdata", 64'(o_dmem_wdata), 64'(32'h1234_5678));
            chk("stall_valid", 64'(o_valid), 64'(1'b0));
            step();
        end
        i_dmem_gnt = 1'b1;
        step();
        i_dmem_gnt = 1'b0;
        chk("stall_done", 64'(o_valid), 64'(1'b1));
        chk("stall_we", 64'(o_control_signal.rd_we), 64'(1'b0));
        step();

        // Timeout with grant never given; late rvalid afterwards is ignored.
        drive(1'b1, 1'b0, MEM_W, 5'd9, 32'h0000_6000, 32'h0, 32'h16);
        step();
        i_valid = 1'b0;
        got = 1'b0;
        n_req = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            if (o_valid) got = 1'b1;
            else begin
                if (o_dmem_req) n_req++;
                step();
            end
        end
        chk("to_seen", 64'(got), 64'(1'b1));
        chk("to_req_cycles", 64'(n_req), 64'(4));
        chk("to_berr", 64'(o_bus_error), 64'(1'b1));
        chk("to_mis", 64'(o_misaligned), 64'(1'b0));
        chk("to_req_lo", 64'(o_dmem_req), 64'(1'b0));
        chk("to_we", 64'(o_control_signal.rd_we), 64'(1'b0));
        i_dmem_rvalid = 1'b1;
        i_dmem_rdata = 32'h5555_5555;
        step();
        i_dmem_rvalid = 1'b0;
        chk("late_rvalid", 64'(o_valid), 64'(1'b0));
        chk("late_ready", 64'(o_ready), 64'(1'b1));

        // Asynchronous reset while waiting for load data.
        drive(1'b1, 1'b0, MEM_W, 5'd9, 32'h0000_7004, 32'h0, 32'h17);
        step();
        i_valid = 1'b0;
        i_dmem_gnt = 1'b1;
        step();
        i_dmem_gnt = 1'b0;
        chk("wait_ready", 64'(o_ready), 64'(1'b0));
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("arst_ready", 64'(o_ready), 64'(1'b1));
        chk("arst_req", 64'(o_dmem_req), 64'(1'b0));
        chk("arst_addr", 64'(o_dmem_addr), 64'(0));
        chk("arst_be", 64'(o_dmem_be), 64'(0));
        chk("arst_valid", 64'(o_valid), 64'(1'b0));
        chk("arst_ctrl", 64'(o_control_signal), 64'(0));
        step();
        i_rst_n = 1'b1;
        i_dmem_rvalid = 1'b1;
        i_dmem_rdata = 32'h1111_1111;
        step();
        i_dmem_rvalid = 1'b0;
        chk("post_rst_rvalid", 64'(o_valid), 64'(1'b0));
        run_vec('{1'b1,1'b0,MEM_W,5'd9,32'h0000_7004,32'h0,32'hDEADBEEF,1'b1,4'b1111,32'h0,
                  1'b1,32'hDEAD_BEEF,1'b1,1'b0,1'b0}, 32'h18);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
